// File: rtl/morse_receiver_if.sv
// morse_receiver_if: key input and decoded-letter outputs of the Morse receiver.
//   key     : Morse key, active high, asynchronous to the receiver clock
//   letter  : index of the last decoded letter (0=A .. 7=H)
//   mcode   : captured symbols, bit i = symbol i, 1 = dash
//   mlength : number of captured symbols, 0..4
//   valid   : one-cycle pulse, a legal letter was just registered
//   err     : one-cycle pulse, the completed pattern was not a legal letter
interface morse_receiver_if;
    logic       key;
    logic [2:0] letter;
    logic [3:0] mcode;
    logic [2:0] mlength;
    logic       valid;
    logic       err;

    modport master (output key, input letter, mcode, mlength, valid, err);
    modport slave  (input key, output letter, mcode, mlength, valid, err);
endinterface

// File: rtl/morse_receiver.sv
// morse_receiver: times key presses/releases, assembles dots and dashes and decodes letters A-H.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of morse_receiver_if (key in; letter/mcode/mlength/valid/err out)
module morse_receiver #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int DASH_UNITS  = 2,
    parameter int GAP_UNITS   = 3
) (
    input logic             clk,
    input logic             reset_n,
    morse_receiver_if.slave bus
);
    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;
    // {length, code} per letter, index 0 = A
    localparam logic [7:0][6:0] TABLE = {
        {3'd4, 4'b0000}, {3'd3, 4'b0011}, {3'd4, 4'b0100}, {3'd1, 4'b0000},
        {3'd3, 4'b0001}, {3'd4, 4'b0101}, {3'd4, 4'b0001}, {3'd2, 4'b0010}
    };

    logic          r_key_meta, r_key_s;
    logic [1:0]    r_state, w_next;
    logic [CW-1:0] r_cyc_cnt;
    logic [2:0]    r_unit_cnt, w_units;
    logic          w_tick, w_dash, w_done, w_hit;
    logic [3:0]    r_work_code;
    logic [2:0]    r_count;
    logic          r_ovf;
    logic [2:0]    w_idx;
    logic [2:0]    r_letter, r_mlength;
    logic [3:0]    r_mcode;
    logic          r_valid, r_err;

    assign w_tick  = r_cyc_cnt == CW'(UNIT_CYCLES - 1);
    // unit count including a tick landing this cycle, so a press/gap of exactly N units is seen as N
    assign w_units = (w_tick && r_unit_cnt != 3'd7) ? r_unit_cnt + 3'd1 : r_unit_cnt;
    assign w_dash  = w_units >= 3'(DASH_UNITS);
    assign w_done  = r_state == S_SPACE && w_units >= 3'(GAP_UNITS);

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = r_key_s ? S_MARK : S_IDLE;
            S_MARK:  w_next = r_key_s ? S_MARK : S_SPACE;
            S_SPACE: w_next = r_key_s ? S_MARK : (w_done ? S_IDLE : S_SPACE);
            default: w_next = S_IDLE;
        endcase
    end

    // table entries are distinct, so any match is the unique match
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (TABLE[i] == {r_count, r_work_code}) begin
                w_hit = !r_ovf;
                w_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_meta <= 1'b0;
            r_key_s    <= 1'b0;
            r_state    <= S_IDLE;
            r_cyc_cnt  <= '0;
            r_unit_cnt <= 3'd0;
        end else begin
            r_key_meta <= bus.key;
            r_key_s    <= r_key_meta;
            r_state    <= w_next;
            if (w_next != r_state || r_state == S_IDLE) begin
                r_cyc_cnt  <= '0;
                r_unit_cnt <= 3'd0;
            end else begin
                r_cyc_cnt  <= w_tick ? '0 : r_cyc_cnt + CW'(1);
                r_unit_cnt <= w_units;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work_code <= 4'd0;
            r_count     <= 3'd0;
            r_ovf       <= 1'b0;
        end else if (r_state == S_MARK && !r_key_s) begin
            if (r_count == 3'd4) begin
                r_ovf <= 1'b1;
            end else begin
                r_work_code[r_count[1:0]] <= w_dash;
                r_count                   <= r_count + 3'd1;
            end
        end else if (w_done) begin
            r_work_code <= 4'd0;
            r_count     <= 3'd0;
            r_ovf       <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_letter  <= 3'd0;
            r_mcode   <= 4'd0;
            r_mlength <= 3'd0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_done && w_hit;
            r_err   <= w_done && !w_hit;
            if (w_done && w_hit) begin
                r_letter  <= w_idx;
                r_mcode   <= r_work_code;
                r_mlength <= r_count;
            end
        end
    end

    assign bus.letter  = r_letter;
    assign bus.mcode   = r_mcode;
    assign bus.mlength = r_mlength;
    assign bus.valid   = r_valid;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: directed and random keying of morse_receiver against a symbol-string reference model.
module tb_morse_receiver;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   nv = 0;
    int   ne = 0;
    int   exp_nv = 0;
    int   exp_ne = 0;
    int   exp_letter = 0;
    int   exp_mcode = 0;
    int   exp_mlength = 0;
    int   pr[8];
    int   gp[8];
    string tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_receiver_if bus();

    morse_receiver #(.UNIT_CYCLES(4), .DASH_UNITS(2), .GAP_UNITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && (bus.valid || bus.err)) begin
            if (bus.valid) nv++;
            if (bus.err) ne++;
            check("valid_err_exclusive", 32'(bus.valid & bus.err), 0);
        end
    end

    // decide the outcome of one completed letter from its dot/dash string
    task automatic finalize(input string s);
        int found = -1;
        if (s.len() <= 4) begin
            for (int i = 0; i < 8; i++) if (s == tbl[i]) found = i;
        end
        if (found < 0) begin
            exp_ne++;
        end else begin
            exp_nv++;
            exp_letter  = found;
            exp_mlength = s.len();
            exp_mcode   = 0;
            for (int i = 0; i < s.len(); i++) if (s[i] == "-") exp_mcode |= (1 << i);
        end
    endtask

    // key pr[i] cycles down, gp[i] cycles up; the last gap is long enough to end the letter
    task automatic play(input int n);
        string s = "";
        int g;
        for (int i = 0; i < n; i++) begin
            bus.key = 1'b1;
            repeat (pr[i]) @(negedge clk);
            bus.key = 1'b0;
            if (pr[i] >= 8) s = {s, "-"};
            else s = {s, "."};
            g = (i == n - 1) ? 20 : gp[i];
            if (g >= 12) begin
                finalize(s);
                s = "";
            end
            repeat (g) @(negedge clk);
        end
    endtask

    task automatic verify(input string tag);
        check({tag, "_valid_cnt"}, nv, exp_nv);
        check({tag, "_err_cnt"}, ne, exp_ne);
        check({tag, "_letter"}, 32'(bus.letter), exp_letter);
        check({tag, "_mcode"}, 32'(bus.mcode), exp_mcode);
        check({tag, "_mlength"}, 32'(bus.mlength), exp_mlength);
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        pr[0] = a; pr[1] = b; pr[2] = c; pr[3] = d;
    endtask

    initial begin
        bus.key = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        verify("reset");
        check("reset_valid", 32'(bus.valid), 0);
        check("reset_err", 32'(bus.err), 0);

        pr[0] = 4;
        play(1);
        verify("single_dot_E");

        pr[0] = 4; pr[1] = 12; gp[0] = 4;
        play(2);
        verify("A");
        set4(4, 4, 4, 4); gp[0] = 4; gp[1] = 4; gp[2] = 4;
        play(4);
        verify("H");

        pr[0] = 8;
        play(1);
        verify("dash_8_T_err");
        pr[0] = 7;
        play(1);
        verify("dot_7_E");

        set4(4, 4, 4, 12); gp[0] = 11; gp[1] = 11; gp[2] = 11;
        play(4);
        verify("gap_11_V_err");
        pr[0] = 4; pr[1] = 4; gp[0] = 12;
        play(2);
        verify("gap_12_two_E");

        set4(12, 4, 4, 4); pr[4] = 4; gp[0] = 4; gp[1] = 4; gp[2] = 4; gp[3] = 4;
        pr[0] = 4;
        play(5);
        verify("overflow");

        bus.key = 1'b1;
        repeat (12) @(negedge clk);
        bus.key = 1'b0;
        repeat (4) @(negedge clk);
        bus.key = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        bus.key = 1'b0;
        exp_letter = 0; exp_mcode = 0; exp_mlength = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        verify("reset_mid_B");
        pr[0] = 12; pr[1] = 4; pr[2] = 4; gp[0] = 4; gp[1] = 4;
        play(3);
        verify("D_after_reset");

        for (int t = 0; t < 30; t++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                pr[i] = $urandom_range(1, 15);
                gp[i] = $urandom_range(1, 14);
            end
            play(n);
            verify("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
